// File: rtl/clz_norm_arbiter.sv
// clz_norm_arbiter: round-robin arbiter sharing one 64-bit CLZ normaliser across NUM_REQ requesters
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester handshake (req_ready one-hot)
//   req_mant, req_exp   packed 64-bit mantissas and EXP_W-bit exponents, requester i in slice i
//   out_valid/ready     result handshake
//   out_id/mant/exp     source index, normalised mantissa, adjusted exponent
//   out_zero, out_uflow mantissa was zero / shift limited by the exponent
//   stat_clr, stat_grants  per-requester saturating grant counters (only with CLZ_NORM_STATS_EN)
// Optional feature macro: CLZ_NORM_STATS_EN
module clz_norm_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int EXP_W = 11,
   parameter int ID_W = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*64-1:0]    req_mant,
   input  logic [NUM_REQ*EXP_W-1:0] req_exp,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_W-1:0]          out_id,
   output logic [63:0]              out_mant,
   output logic [EXP_W-1:0]         out_exp,
   output logic                     out_zero,
   output logic                     out_uflow
`ifdef CLZ_NORM_STATS_EN
   ,
   input  logic                     stat_clr,
   output logic [NUM_REQ*16-1:0]    stat_grants
`endif
);
   logic [ID_W-1:0]  ptr_q, ptr_d, gnt_id, j;
   logic             gnt_any, can_acc, stall, xfer;
   logic [63:0]      sel_mant;
   logic [EXP_W-1:0] sel_exp;
   logic             s1_valid_q, s1_valid_d;
   logic [63:0]      s1_mant_q, s1_mant_d;
   logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
   logic [ID_W-1:0]  s1_id_q, s1_id_d;
   logic             out_valid_q, out_valid_d, out_zero_q, out_zero_d, out_uflow_q, out_uflow_d;
   logic [63:0]      out_mant_q, out_mant_d;
   logic [EXP_W-1:0] out_exp_q, out_exp_d;
   logic [ID_W-1:0]  out_id_q, out_id_d;
   logic [5:0]       clz, sh;
   logic             fits, zero;
   always_comb begin
      stall = out_valid_q & ~out_ready;
      // stage 1 may still fill while stalled as long as it is empty
      can_acc = (~stall | ~s1_valid_q) & ~rst;
      gnt_any = 1'b0;
      gnt_id = '0;
      j = '0;
      // descending scan so the nearest index at/after the pointer wins
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (req_valid[j]) begin
            gnt_any = 1'b1;
            gnt_id = j;
         end
      end
      req_ready = '0;
      sel_mant = '0;
      sel_exp = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = can_acc & gnt_any & (gnt_id == ID_W'(i));
         if (gnt_id == ID_W'(i)) begin
            sel_mant = req_mant[i*64 +: 64];
            sel_exp = req_exp[i*EXP_W +: EXP_W];
         end
      end
      xfer = |req_ready;
      ptr_d = ~xfer ? ptr_q : (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      s1_valid_d = can_acc ? xfer : s1_valid_q;
      s1_mant_d = xfer ? sel_mant : s1_mant_q;
      s1_exp_d = xfer ? sel_exp : s1_exp_q;
      s1_id_d = xfer ? gnt_id : s1_id_q;
   end
   always_comb begin
      clz = '0;
      // last write is the highest set bit
      for (int i = 0; i < 64; i++) if (s1_mant_q[i]) clz = 6'(63 - i);
      zero = s1_mant_q == 64'd0;
      fits = {{EXP_W{1'b0}}, clz} <= {6'd0, s1_exp_q};
      sh = fits ? clz : 6'(s1_exp_q);
      out_valid_d = stall ? out_valid_q : s1_valid_q;
      out_id_d = stall ? out_id_q : s1_id_q;
      out_mant_d = stall ? out_mant_q : s1_mant_q << sh;
      out_exp_d = stall ? out_exp_q : (zero | ~fits) ? '0 : s1_exp_q - EXP_W'(clz);
      out_zero_d = stall ? out_zero_q : zero;
      out_uflow_d = stall ? out_uflow_q : ~zero & ~fits;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         s1_valid_q <= 1'b0;
         s1_mant_q <= '0;
         s1_exp_q <= '0;
         s1_id_q <= '0;
         out_valid_q <= 1'b0;
         out_id_q <= '0;
         out_mant_q <= '0;
         out_exp_q <= '0;
         out_zero_q <= 1'b0;
         out_uflow_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_mant_q <= s1_mant_d;
         s1_exp_q <= s1_exp_d;
         s1_id_q <= s1_id_d;
         out_valid_q <= out_valid_d;
         out_id_q <= out_id_d;
         out_mant_q <= out_mant_d;
         out_exp_q <= out_exp_d;
         out_zero_q <= out_zero_d;
         out_uflow_q <= out_uflow_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_id = out_id_q;
   assign out_mant = out_mant_q;
   assign out_exp = out_exp_q;
   assign out_zero = out_zero_q;
   assign out_uflow = out_uflow_q;
`ifdef CLZ_NORM_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      logic [15:0] cnt_q, cnt_d;
      // clear beats increment; counter saturates at all-ones
      always_comb cnt_d = stat_clr ? '0 : (req_ready[g] && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt_q <= '0;
         else cnt_q <= cnt_d;
      end
      assign stat_grants[g*16 +: 16] = cnt_q;
   end
`endif
endmodule

// File: tb/tb_clz_norm_arbiter.sv
// tb_clz_norm_arbiter: directed bench with a queue-based reference model for clz_norm_arbiter
module tb_clz_norm_arbiter;
   localparam int NUM_REQ = 4;
   localparam int EXP_W = 11;
   localparam int ID_W = 2;
   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*64-1:0]    req_mant = '0;
   logic [NUM_REQ*EXP_W-1:0] req_exp = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic [ID_W-1:0]          out_id;
   logic [63:0]              out_mant;
   logic [EXP_W-1:0]         out_exp;
   logic                     out_zero, out_uflow;
`ifdef CLZ_NORM_STATS_EN
   logic                     stat_clr = 1'b0;
   logic [NUM_REQ*16-1:0]    stat_grants;
`endif
   clz_norm_arbiter #(.NUM_REQ(NUM_REQ), .EXP_W(EXP_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_mant(req_mant), .req_exp(req_exp),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow)
`ifdef CLZ_NORM_STATS_EN
      , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
   );
   always #5 clk = ~clk;
   int tests = 0;
   int fails = 0;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h, want %h (t=%0t)", n, a, e, $time);
      end
   endtask
   // reference model: in-flight results in accept order, each with the first cycle it may appear
   typedef struct {
      logic [ID_W-1:0]  id;
      logic [63:0]      m;
      logic [EXP_W-1:0] e;
      logic             z, u;
      int               rdy;
   } item_t;
   item_t q[$];
   item_t x_it;
   int ptr = 0;
   int cyc = 0;
   bit x_do, x_pop;
   int x_id;
   function automatic item_t mk(input int id, input logic [63:0] m, input logic [EXP_W-1:0] e);
      item_t it;
      it.id = id[ID_W-1:0];
      it.rdy = 0;
      if (m == 64'd0) begin
         it.m = '0; it.e = '0; it.z = 1'b1; it.u = 1'b0;
      end else begin
         while (!m[63] && e != 0) begin
            m = m << 1;
            e = e - 1'b1;
         end
         it.m = m; it.e = e; it.z = 1'b0; it.u = !m[63];
      end
      return it;
   endfunction
   always @(negedge clk) begin
      bit ev, cap, found;
      int g;
      logic [NUM_REQ-1:0] er;
      if (rst) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_out_mant", out_mant, 0);
         chk("rst_out_misc", {out_id, out_exp, out_zero, out_uflow}, 0);
         x_do = 0;
         x_pop = 0;
      end else begin
         ev = q.size() > 0 && q[0].rdy <= cyc;
         cap = !(ev && !out_ready && q.size() >= 2);
         found = 0;
         g = 0;
         for (int k = 0; k < NUM_REQ; k++)
            if (!found && req_valid[(ptr + k) % NUM_REQ]) begin
               found = 1;
               g = (ptr + k) % NUM_REQ;
            end
         er = (cap && found) ? NUM_REQ'(1) << g : '0;
         chk("model_req_ready", req_ready, er);
         chk("model_out_valid", out_valid, ev);
         if (ev) begin
            chk("model_out_id", out_id, q[0].id);
            chk("model_out_mant", out_mant, q[0].m);
            chk("model_out_exp", out_exp, q[0].e);
            chk("model_out_flags", {out_zero, out_uflow}, {q[0].z, q[0].u});
         end
         x_do = cap && found;
         x_id = g;
         x_pop = ev && out_ready;
         if (x_do) x_it = mk(g, req_mant[g*64 +: 64], req_exp[g*EXP_W +: EXP_W]);
      end
   end
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         ptr = 0;
      end else begin
         if (x_pop) begin
            void'(q.pop_front());
            if (q.size() > 0 && q[0].rdy < cyc + 1) q[0].rdy = cyc + 1;
         end
         if (x_do) begin
            x_it.rdy = cyc + 2;
            q.push_back(x_it);
            ptr = (x_id + 1) % NUM_REQ;
         end
      end
      cyc++;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // one cycle, withdrawing any request the DUT accepted
   task automatic step();
      logic [NUM_REQ-1:0] gr;
      @(negedge clk);
      gr = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~gr;
   endtask
   logic [63:0] vm[8] = '{64'h02FF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 64'h0400_0000_0000_0000,
                          64'h0400_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h1, 64'h0000_0000_FFFF_0000};
   int vx[8] = '{100, 50, 10, 5, 4, 0, 2047, 40};
   logic [63:0] wm[8] = '{64'hBFFF_FFFF_FFFF_FFC0, 64'h0, 64'h400, 64'h8000_0000_0000_0000,
                          64'h4000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'hFFFF_0000_0000_0000};
   int we[8] = '{94, 0, 0, 0, 0, 0, 1984, 8};
   logic [1:0] wf[8] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int r;
         r = i % NUM_REQ;
         req_mant[r*64 +: 64] = vm[i];
         req_exp[r*EXP_W +: EXP_W] = EXP_W'(vx[i]);
         req_valid = '0;
         req_valid[r] = 1'b1;
         @(negedge clk);
         chk("vec_ready", req_ready, NUM_REQ'(1) << r);
         tick();
         req_valid = '0;
         tick();
         @(negedge clk);
         chk("vec_valid", out_valid, 1);
         chk("vec_id", out_id, r);
         chk("vec_mant", out_mant, wm[i]);
         chk("vec_exp", out_exp, we[i]);
         chk("vec_flags", {out_zero, out_uflow}, wf[i]);
         tick();
      end
      for (int r = 0; r < NUM_REQ; r++) begin
         req_mant[r*64 +: 64] = 64'h0000_1234_0000_0000 >> (r * 4);
         req_exp[r*EXP_W +: EXP_W] = EXP_W'(200 + r);
      end
      req_valid = '1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            chk("rr_valid", out_valid, 1);
            chk("rr_id", out_id, (k - 2) % NUM_REQ);
         end
         tick();
         if (k == 7) req_valid = '0;
      end
      out_ready = 1'b0;
      req_valid = 4'b0111;
      for (int k = 0; k < 9; k++) begin
         logic [NUM_REQ-1:0] gr;
         @(negedge clk);
         if (k >= 2 && k <= 4) begin
            chk("bp_ready_blocked", req_ready, 0);
            chk("bp_hold_id", out_id, 0);
         end
         if (k >= 5 && k <= 7) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_id", out_id, k - 5);
         end
         if (k == 8) chk("bp_empty", out_valid, 0);
         gr = req_ready;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~gr;
         if (k == 4) out_ready = 1'b1;
      end
      out_ready = 1'b0;
      req_valid = 4'b1100;
      step();
      step();
      chk("mid_full_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      req_valid = 4'b1010;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_grant", req_ready, 4'b0010);
      repeat (4) step();
`ifdef CLZ_NORM_STATS_EN
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("stat_cleared", stat_grants[47:32], 0);
      repeat (3) begin
         req_valid = 4'b0100;
         step();
      end
      chk("stat_three", stat_grants[47:32], 3);
      req_valid = 4'b0100;
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("stat_clr_priority", stat_grants[47:32], 0);
`endif
      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
